// File: rtl/pipeline.sv
// ---------------------------------------------------------------------------
// pipeline: shared types, constants and small helper functions for the
// execute-stage blocks. The multiply/divide sequencer (mdu_seq) uses the
// op/state encodings and the negate/extend helpers defined here.
// ---------------------------------------------------------------------------
package pipeline;

    localparam int XLEN           = 64;
    localparam int MDU_WORD_ITERS = 32;

    // RV64 M-extension funct3 encodings.
    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } mdu_funct3_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // Two's-complement negate when neg is set (XLEN wide).
    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Two's-complement negate when neg is set (2*XLEN wide, full product).
    function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Sign-extend bit 31 across the upper word.
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Zero-extend the low word.
    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq: iterative multiply/divide sequencer for the RV64 M extension.
// Accepts one MUL/DIV/REM-class op while `start` is held, iterates one bit
// per cycle (shift-add multiply, restoring divide) on operand magnitudes,
// applies the sign fixup on the last iteration and pulses `done` for one
// cycle with the registered `result`. Divide-by-zero and signed overflow
// finish in the accept cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   level: an M-op is held by execute until done
//   funct3    in   op select (MUL..REMU)
//   word      in   *W variant (32-bit compute, sign-extended result)
//   rs1_data  in   multiplicand / dividend
//   rs2_data  in   multiplier / divisor
//   flush     in   abort current op; blocks acceptance in IDLE
//   stall     out  start & ~done
//   done      out  result valid this cycle (single-cycle pulse)
//   result    out  registered result
// ---------------------------------------------------------------------------
module mdu_seq
    import pipeline::*;
#(
    parameter int XLEN = pipeline::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_e        state_reg;
    mdu_funct3_e       op_reg;
    logic              word_reg;
    logic              neg_q_reg;   // negate product / quotient
    logic              neg_r_reg;   // negate remainder (dividend sign)
    logic [CW-1:0]     count_reg;
    // Multiply: acc_reg = product accumulator, opa_reg = shifting multiplicand,
    //           opb_reg = shifting multiplier.
    // Divide:   acc_reg[XLEN-1:0] = partial remainder, opa_reg[XLEN-1:0] =
    //           divisor, opb_reg = dividend shifting out / quotient shifting in.
    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] opa_reg;
    logic [XLEN-1:0]   opb_reg;
    logic [XLEN-1:0]   result_reg;
    logic              done_reg;

    // ---------------- accept-cycle decode ----------------
    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            a_neg, b_neg;
    logic            is_div, is_rem;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] min_val;
    logic [XLEN-1:0] special_raw, special_res;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (mdu_funct3_e'(funct3))
            F3_MULH:        begin sgn_a = 1'b1; sgn_b = 1'b1; end
            F3_MULHSU:      begin sgn_a = 1'b1; end
            F3_DIV, F3_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            default:        ;
        endcase
    end

    always_comb begin
        a_ext = word ? (sgn_a ? sext_word(rs1_data) : zext_word(rs1_data)) : rs1_data;
        b_ext = word ? (sgn_b ? sext_word(rs2_data) : zext_word(rs2_data)) : rs2_data;
        a_neg = sgn_a & a_ext[XLEN-1];
        b_neg = sgn_b & b_ext[XLEN-1];
        a_mag = cond_neg_x(a_ext, a_neg);
        b_mag = cond_neg_x(b_ext, b_neg);

        is_div = funct3[2];
        is_rem = funct3[1];
        // Word operands are already sign-extended, so the word minimum is
        // compared in its extended form and -1 is all ones in both widths.
        min_val  = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (b_ext == '0);
        div_ovf  = is_div & ~funct3[0] & (a_ext == min_val) & (&b_ext);

        if (div_zero)
            special_raw = is_rem ? a_ext : '1;
        else
            special_raw = is_rem ? '0 : a_ext;
        special_res = word ? sext_word(special_raw) : special_raw;
    end

    // ---------------- per-iteration datapath ----------------
    logic [2*XLEN-1:0] mul_acc, prod_fix;
    logic [XLEN:0]     rem_shift, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new, quot_new;
    logic [XLEN-1:0]   final_raw, final_res;

    always_comb begin
        mul_acc   = acc_reg + (opb_reg[0] ? opa_reg : '0);
        rem_shift = {acc_reg[XLEN-1:0], opb_reg[XLEN-1]};
        diff      = rem_shift - {1'b0, opa_reg[XLEN-1:0]};
        // Remainder stays below twice the divisor, so bit XLEN is the sign.
        q_bit     = ~diff[XLEN];
        rem_new   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_new  = {opb_reg[XLEN-2:0], q_bit};
        prod_fix  = cond_neg_2x(mul_acc, neg_q_reg);

        if (op_reg[2])
            final_raw = op_reg[1] ? cond_neg_x(rem_new, neg_r_reg)
                                  : cond_neg_x(quot_new, neg_q_reg);
        else
            final_raw = (op_reg == F3_MUL) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
        final_res = word_reg ? sext_word(final_raw) : final_raw;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= MDU_IDLE;
            op_reg     <= F3_MUL;
            word_reg   <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= MDU_IDLE;
            end else begin
                unique case (state_reg)
                    MDU_IDLE: begin
                        if (start) begin
                            op_reg    <= mdu_funct3_e'(funct3);
                            word_reg  <= word;
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            acc_reg   <= '0;
                            if (div_zero || div_ovf) begin
                                result_reg <= special_res;
                                done_reg   <= 1'b1;
                                count_reg  <= '0;
                                state_reg  <= MDU_DONE;
                            end else begin
                                count_reg <= word ? CW'(MDU_WORD_ITERS) : CW'(XLEN);
                                state_reg <= MDU_BUSY;
                                if (is_div) begin
                                    opa_reg <= {{XLEN{1'b0}}, b_mag};
                                    // Word dividend is left-aligned so its bits
                                    // shift out first over 32 iterations.
                                    opb_reg <= word ? (a_mag << MDU_WORD_ITERS) : a_mag;
                                end else begin
                                    opa_reg <= {{XLEN{1'b0}}, a_mag};
                                    opb_reg <= b_mag;
                                end
                            end
                        end
                    end
                    MDU_BUSY: begin
                        count_reg <= count_reg - 1'b1;
                        if (op_reg[2]) begin
                            acc_reg <= {{XLEN{1'b0}}, rem_new};
                            opb_reg <= quot_new;
                        end else begin
                            acc_reg <= mul_acc;
                            opa_reg <= opa_reg << 1;
                            opb_reg <= opb_reg >> 1;
                        end
                        // Last iteration: latch the fixed-up result directly.
                        if (count_reg == CW'(1)) begin
                            result_reg <= final_res;
                            done_reg   <= 1'b1;
                            state_reg  <= MDU_DONE;
                        end
                    end
                    MDU_DONE: state_reg <= MDU_IDLE;
                    default:  state_reg <= MDU_IDLE;
                endcase
            end
        end
    end

    assign done   = done_reg & ~flush;
    assign stall  = start & ~done;
    assign result = result_reg;

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the RV64 M extension. It sits beside the integer execute unit in the execute stage. It accepts one MUL/DIV/REM-class operation from execute and stalls the pipeline while it iterates, running shift-add multiplication or restoring division one bit per cycle. It then returns a single-cycle `done` pulse with the XLEN result, which execute muxes into its `data` field.

## Interface
Parameters:
- `XLEN`: default `pipeline::XLEN` (64); datapath width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: execute holds an M-op. It is level, not a pulse, and stays high with operands stable until `done`.
- `funct3` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word` in 1: *W variant (MULW/DIVW/DIVUW/REMW/REMUW).
- `rs1_data` in XLEN: multiplicand / dividend.
- `rs2_data` in XLEN: multiplier / divisor.
- `flush` in 1: abort the current op (branch redirect / trap).
- `stall` out 1: freezes the pipeline; combinational, equal to `start & ~done`.
- `done` out 1: result valid this cycle.
- `result` out XLEN: registered result.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE → BUSY**
  - Condition: `start & ~flush`.
  - Actions: latch operand magnitudes, sign-fixup flags, op and word; load the iteration counter with N (64, or 32 if `word`).
- **IDLE → DONE directly** (special cases, result latched in the accept cycle):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM, dividend = most-negative, divisor = −1): quotient = dividend; remainder = 0.
  - Word variants use the 32-bit most-negative value and 32-bit −1.
- **BUSY**
  - Each cycle: one iteration, counter decrements.
  - Multiply: add the shifted multiplicand when the current multiplier LSB is set; the product register is 2·XLEN.
  - Divide: shift the remainder left, subtract the divisor, keep the difference if non-negative, set the quotient bit.
  - When the counter reaches 0: apply the sign fixup (two's-complement negate) to the result and go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- **Signedness**:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: signed.
  - The remainder takes the dividend's sign.
  - The quotient is negated when the operand signs differ.
- **Result selection**:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV*: quotient.
  - REM*: remainder.
- **Word rule**: use operand bits [31:0], sign- or zero-extended per op; compute at 32 bits; `result` = sign-extended bit 31 of the 32-bit result (DIVUW/REMUW included).
- **Flush**:
  - Any state goes to IDLE on the next edge.
  - `done` is gated to 0 during a flush cycle.
  - A flush in IDLE blocks acceptance.
- **Reset (async, any time)**: state IDLE, counter 0, `done`=0, `result`=0, all internal registers 0.

## Timing
- Cycle 0: `start` first high, op accepted, `stall`=1.
- Full op: BUSY occupies cycles 1..N; DONE in cycle N+1.
  - Latency is 65 cycles (XLEN ops) or 33 cycles (word ops) from the accept cycle to `done`.
- Special case: DONE in cycle 1 (latency 1).
- `stall`: high in cycles 0..N (or cycle 0 only for special cases); low in the DONE cycle, so the pipeline advances on that edge.
- Next op: `start` seen in the cycle after DONE is a new op; accepted, with no bubble required.
- Held `start`: `start` held across DONE without the pipeline advancing is a protocol violation; the bench flags it via assertion.
- `result`: stable from DONE until the next accept or reset.

## Structure
- In package `pipeline`:
  - `typedef enum logic [2:0] mdu_funct3_e` (8 op encodings).
  - `typedef enum logic [1:0] mdu_state_e` (IDLE/BUSY/DONE).
  - Localparam `MDU_WORD_ITERS` = 32.
- Single flat module: FSM, counter, product/remainder/quotient registers. No sub-module; negate/extend helpers are package functions.
- Top-level wiring: `stall` is ORed with the hazard stall at top level; `done`/`result` feed the execute-stage data mux.

## Test plan
- MUL: rs1=7, rs2=−3 → `result`=0xFFFF_FFFF_FFFF_FFEB; `done` at cycle 65; `stall` high cycles 0–64.
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE; MULH on the same operands → 0.
- Divide by zero:
  - DIV 100/0 → all ones, `done` at cycle 1.
  - REM 100/0 → 100.
  - DIVU 5/0 → all ones.
- Signed overflow:
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
  - REM → 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Word ops:
  - DIVW −7/2 (rs1 upper bits garbage 0xDEAD_BEEF) → −3; REMW → −1; `done` at cycle 33.
  - DIVUW 0xFFFF_FFFE/1 → 0xFFFF_FFFF_FFFF_FFFE.
- Flush and reset mid-op:
  - `flush` at cycle 10 of DIV → no `done`; IDLE at cycle 11.
  - MUL 2×3 accepted at cycle 11 → 6 at cycle 76.
  - `rst_n` low mid-BUSY → `done`=0, `result`=0 immediately; clean op after release.
